// File: rtl/spin_wheel.sv
// spin_wheel: eight-position LED spinner that runs, brakes over a random number of slowing steps, then halts.
// Optional INTERNAL_RNG_EN replaces rand_i with an internal 4-bit LFSR as the brake random source.
module spin_wheel #(
    parameter int RUN_DIV    = 1,
    parameter int BRAKE_BASE = 2,
    parameter int MAX_GAP    = 3
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       stop_i,
    input  logic [3:0] rand_i,
    output logic [2:0] pos_o,
    output logic       running_o
);
    typedef enum logic [1:0] {RUN, BRAKE, STOPPED} state_t;
    state_t     state_q, state_d;
    logic [2:0] pos_q, pos_d;
    logic       running_q, running_d;
    logic [3:0] div_q, div_d, gap_q, gap_d, wait_q, wait_d;
    logic [4:0] rem_q, rem_d;
    logic [3:0] rnd;
`ifdef INTERNAL_RNG_EN
    logic [3:0] lfsr_q, lfsr_d;
    logic       unused_rand;
    assign unused_rand = ^rand_i;
    assign rnd = lfsr_q;
    always_comb lfsr_d = tick_i ? {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]} : lfsr_q;
    always_ff @(posedge clk_i) lfsr_q <= rst_i ? 4'b0001 : lfsr_d;
`else
    assign rnd = rand_i;
`endif
    always_comb begin
        state_d   = state_q;
        pos_d     = pos_q;
        running_d = running_q;
        div_d     = div_q;
        gap_d     = gap_q;
        wait_d    = wait_q;
        rem_d     = rem_q;
        case (state_q)
            RUN: begin
                if (stop_i) begin
                    state_d = BRAKE;
                    rem_d   = 5'(BRAKE_BASE) + {1'b0, rnd};
                    gap_d   = 4'd1;
                    wait_d  = 4'd0;
                    div_d   = 4'd0;
                end else if (tick_i) begin
                    pos_d = (div_q == 4'(RUN_DIV - 1)) ? pos_q + 3'd1 : pos_q;
                    div_d = (div_q == 4'(RUN_DIV - 1)) ? 4'd0 : div_q + 4'd1;
                end
            end
            BRAKE: begin
                if (!stop_i) begin
                    state_d = RUN;
                    div_d   = 4'd0;
                end else if (tick_i) begin
                    if (wait_q + 4'd1 == gap_q) begin
                        pos_d  = pos_q + 3'd1;
                        rem_d  = rem_q - 5'd1;
                        wait_d = 4'd0;
                        gap_d  = (gap_q == 4'(MAX_GAP)) ? gap_q : gap_q + 4'd1;
                        // the final step lands together with the halt
                        if (rem_q == 5'd1) begin
                            state_d   = STOPPED;
                            running_d = 1'b0;
                        end
                    end else begin
                        wait_d = wait_q + 4'd1;
                    end
                end
            end
            default: begin
                if (!stop_i) begin
                    state_d   = RUN;
                    running_d = 1'b1;
                    div_d     = 4'd0;
                end
            end
        endcase
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= RUN;
            pos_q     <= 3'd0;
            running_q <= 1'b1;
            div_q     <= 4'd0;
            gap_q     <= 4'd1;
            wait_q    <= 4'd0;
            rem_q     <= 5'd0;
        end else begin
            state_q   <= state_d;
            pos_q     <= pos_d;
            running_q <= running_d;
            div_q     <= div_d;
            gap_q     <= gap_d;
            wait_q    <= wait_d;
            rem_q     <= rem_d;
        end
    end
    assign pos_o     = pos_q;
    assign running_o = running_q;
endmodule

// File: tb/tb_spin_wheel.sv
// tb_spin_wheel: randomized and directed checks of spin_wheel against a phase/tick-count reference model.
module tb_spin_wheel;
    localparam int RUN_DIV    = 1;
    localparam int BRAKE_BASE = 2;
    localparam int MAX_GAP    = 3;
    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic       tick_i = 1'b0;
    logic       stop_i = 1'b0;
    logic [3:0] rand_i = 4'd0;
    logic [2:0] pos_o;
    logic       running_o;
    int n_chk = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;
    // model: phase (0 run, 1 brake, 2 stopped), position at phase entry, ticks counted in phase
    int m_mode = 0;
    int m_base = 0;
    int m_ticks = 0;
    int m_steps = 0;
    int m_lfsr = 1;
    spin_wheel #(.RUN_DIV(RUN_DIV), .BRAKE_BASE(BRAKE_BASE), .MAX_GAP(MAX_GAP)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .tick_i(tick_i), .stop_i(stop_i),
        .rand_i(rand_i), .pos_o(pos_o), .running_o(running_o)
    );
    always #5 clk_i = ~clk_i;
    function automatic int steps_done(int t);
        int c = 0;
        for (int k = 0; k < 64; k++) begin
            int g = (k + 1 < MAX_GAP) ? k + 1 : MAX_GAP;
            if (c + g > t) return k;
            c += g;
        end
        return 64;
    endfunction
    function automatic int exp_pos();
        if (m_mode == 0) return (m_base + m_ticks / RUN_DIV) % 8;
        if (m_mode == 1) return (m_base + steps_done(m_ticks)) % 8;
        return m_base;
    endfunction
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    task automatic cyc(input bit stop, input bit tick, input int rnd, input bit rst);
        int p, src;
        stop_i = stop; tick_i = tick; rand_i = 4'(rnd); rst_i = rst;
        @(posedge clk_i);
        p = exp_pos();
`ifdef INTERNAL_RNG_EN
        src = m_lfsr;
`else
        src = rnd;
`endif
        if (rst) begin
            m_mode = 0; m_base = 0; m_ticks = 0; m_lfsr = 1;
        end else begin
            if (tick) m_lfsr = ((m_lfsr << 1) & 14) | (((m_lfsr >> 3) ^ (m_lfsr >> 2)) & 1);
            if (m_mode == 0) begin
                if (stop) begin
                    m_base = p; m_ticks = 0; m_steps = BRAKE_BASE + src; m_mode = 1;
                end else if (tick) m_ticks++;
            end else if (m_mode == 1) begin
                if (!stop) begin
                    m_base = p; m_ticks = 0; m_mode = 0;
                end else if (tick) begin
                    m_ticks++;
                    if (steps_done(m_ticks) >= m_steps) begin
                        m_base = (m_base + m_steps) % 8; m_mode = 2;
                    end
                end
            end else if (!stop) begin
                m_base = p; m_ticks = 0; m_mode = 0;
            end
        end
        #1;
    endtask
    always @(negedge clk_i) begin
        if (cmp_en) begin
            n_chk++;
            if (pos_o !== 3'(exp_pos()) || running_o !== (m_mode != 2)) begin
                n_fail++;
                $display("FAIL model: pos %0d run %0b expected pos %0d run %0b at %0t",
                         pos_o, running_o, exp_pos(), m_mode != 2, $time);
            end
        end
    end
    initial begin
        int fall;
        bit st;
        cyc(0, 0, 0, 1);
        cyc(0, 0, 0, 1);
        cmp_en = 1'b1;
        chk("reset_pos", pos_o, 0);
        chk("reset_run", running_o, 1);
`ifdef INTERNAL_RNG_EN
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        chk("lfsr_pos3", pos_o, 3);
        fall = 0;
        cyc(1, 0, 0, 0);
        for (int i = 1; i <= 60; i++) begin
            cyc(1, 1, 0, 0);
            if (!running_o && fall == 0) fall = i;
        end
        chk("lfsr_brake_ticks", fall, 30);
        chk("lfsr_final_pos", pos_o, 6);
        cyc(0, 0, 0, 0);
`else
        cyc(0, 0, 0, 0);
        repeat (3) cyc(0, 1, 0, 0);
        chk("run_pos3", pos_o, 3);
        chk("run_running", running_o, 1);
        repeat (5) cyc(0, 1, 0, 0);
        chk("run_wrap", pos_o, 0);
        repeat (5) cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("entry_tick_discard", pos_o, 5);
        cyc(1, 1, 0, 0);
        chk("brk2_t1_pos", pos_o, 6);
        chk("brk2_t1_run", running_o, 1);
        cyc(1, 1, 0, 0);
        chk("brk2_t2_pos", pos_o, 6);
        cyc(1, 1, 0, 0);
        chk("brk2_t3_pos", pos_o, 7);
        chk("brk2_t3_run", running_o, 0);
        repeat (4) cyc(1, 1, 0, 0);
        chk("stopped_hold", pos_o, 7);
        cyc(0, 0, 0, 0);
        chk("restart_run", running_o, 1);
        cyc(0, 1, 0, 0);
        chk("restart_step", pos_o, 0);
        cyc(1, 1, 15, 0);
        chk("brk17_entry", pos_o, 0);
        fall = 0;
        for (int i = 1; i <= 60; i++) begin
            cyc(1, 1, 15, 0);
            if (!running_o && fall == 0) fall = i;
        end
        chk("brk17_ticks", fall, 48);
        chk("brk17_pos", pos_o, 1);
        cyc(0, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 0, 3, 0);
        cyc(1, 1, 3, 0);
        chk("abort_one_step", pos_o, 3);
        cyc(0, 1, 0, 0);
        chk("abort_hold", pos_o, 3);
        chk("abort_run", running_o, 1);
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        chk("abort_resume", pos_o, 5);
        cyc(1, 0, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 0, 1);
        chk("rst_mid_pos", pos_o, 0);
        chk("rst_mid_run", running_o, 1);
`endif
        st = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 39) == 0) st = ~st;
            cyc(st, $urandom_range(0, 1) == 1, $urandom_range(0, 15), $urandom_range(0, 999) == 0);
        end
        cmp_en = 1'b0;
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end
endmodule
